// File: rtl/spi_master_byte.sv
// Byte-wide SPI mode 0 master (CPOL=0, CPHA=0, MSB first) with a chip-select frame
// around each byte and a valid/ready request interface.
module spi_master_byte #(
   parameter int CLK_DIV  = 3,
   parameter int CS_SETUP = 1,
   parameter int CS_HOLD  = 1,
   parameter int CS_GAP   = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       busy,
   output logic       CS_n,
   output logic       SCLK,
   output logic       MOSI,
   input  logic       MISO,
   output logic [2:0] dbg_state
);

   // Request handshake: a byte is accepted on a clk edge where tx_valid & tx_ready;
   // tx_ready is high only in IDLE, so inputs are ignored for the whole frame.

   // One phase counter times every state; it is sized for the longest phase.
   localparam int MAX_A  = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
   localparam int MAX_B  = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
   localparam int MAX_PH = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CW     = $clog2(MAX_PH + 1);

   localparam logic [CW-1:0] L_DIV   = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] L_SETUP = CW'(CS_SETUP - 1);
   localparam logic [CW-1:0] L_HOLD  = CW'(CS_HOLD - 1);
   localparam logic [CW-1:0] L_GAP   = CW'((CS_GAP > 0) ? CS_GAP - 1 : 0);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_LOW   = 3'd2,
      S_HIGH  = 3'd3,
      S_HOLD  = 3'd4,
      S_GAP   = 3'd5
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [CW-1:0]   r_cnt, w_cnt_nxt;
   logic [2:0]      r_bit, w_bit_nxt;
   logic [7:0]      r_tx_sh, w_tx_sh_nxt;
   logic [7:0]      r_rx_sh, w_rx_sh_nxt;
   logic [7:0]      r_rx_data, w_rx_data_nxt;
   logic            r_rx_valid, w_rx_valid_nxt;
   logic            r_cs_n, w_cs_n_nxt;
   logic            r_sclk, w_sclk_nxt;
   logic            r_mosi, w_mosi_nxt;
   logic            r_tx_ready, w_tx_ready_nxt;
   logic            r_busy, w_busy_nxt;

   logic            w_done;
   logic            w_accept;

   assign w_done   = (r_cnt == '0);
   assign w_accept = (r_state == S_IDLE) && tx_valid && r_tx_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_bit      <= 3'd0;
         r_tx_sh    <= 8'h00;
         r_rx_sh    <= 8'h00;
         r_rx_data  <= 8'h00;
         r_rx_valid <= 1'b0;
         r_cs_n     <= 1'b1;
         r_sclk     <= 1'b0;
         r_mosi     <= 1'b0;
         r_tx_ready <= 1'b1;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_bit      <= w_bit_nxt;
         r_tx_sh    <= w_tx_sh_nxt;
         r_rx_sh    <= w_rx_sh_nxt;
         r_rx_data  <= w_rx_data_nxt;
         r_rx_valid <= w_rx_valid_nxt;
         r_cs_n     <= w_cs_n_nxt;
         r_sclk     <= w_sclk_nxt;
         r_mosi     <= w_mosi_nxt;
         r_tx_ready <= w_tx_ready_nxt;
         r_busy     <= w_busy_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = S_SETUP;
         S_SETUP: if (w_done)   w_state_nxt = S_LOW;
         S_LOW:   if (w_done)   w_state_nxt = S_HIGH;
         S_HIGH:  if (w_done)   w_state_nxt = (r_bit == 3'd0) ? S_HOLD : S_LOW;
         S_HOLD:  if (w_done)   w_state_nxt = (CS_GAP == 0) ? S_IDLE : S_GAP;
         S_GAP:   if (w_done)   w_state_nxt = S_IDLE;
         default:               w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_cnt_nxt      = w_done ? r_cnt : r_cnt - CW'(1);
      w_bit_nxt      = r_bit;
      w_tx_sh_nxt    = r_tx_sh;
      w_rx_sh_nxt    = r_rx_sh;
      w_rx_data_nxt  = r_rx_data;
      w_rx_valid_nxt = 1'b0;
      w_cs_n_nxt     = r_cs_n;
      w_sclk_nxt     = r_sclk;
      w_mosi_nxt     = r_mosi;
      w_tx_ready_nxt = r_tx_ready;
      w_busy_nxt     = r_busy;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_tx_sh_nxt    = tx_data;
               w_bit_nxt      = 3'd7;
               w_cs_n_nxt     = 1'b0;
               w_mosi_nxt     = tx_data[7];
               w_tx_ready_nxt = 1'b0;
               w_busy_nxt     = 1'b1;
               w_cnt_nxt      = L_SETUP;
            end
         end
         S_SETUP: begin
            if (w_done) w_cnt_nxt = L_DIV;
         end
         S_LOW: begin
            // MISO is sampled on the edge that raises SCLK, i.e. just before it rises.
            if (w_done) begin
               w_sclk_nxt  = 1'b1;
               w_rx_sh_nxt = {r_rx_sh[6:0], MISO};
               w_cnt_nxt   = L_DIV;
            end
         end
         S_HIGH: begin
            if (w_done) begin
               w_sclk_nxt = 1'b0;
               if (r_bit == 3'd0) begin
                  w_mosi_nxt = 1'b0;
                  w_cnt_nxt  = L_HOLD;
               end else begin
                  w_bit_nxt   = r_bit - 3'd1;
                  w_tx_sh_nxt = {r_tx_sh[6:0], 1'b0};
                  w_mosi_nxt  = r_tx_sh[6];
                  w_cnt_nxt   = L_DIV;
               end
            end
         end
         S_HOLD: begin
            if (w_done) begin
               w_cs_n_nxt     = 1'b1;
               w_rx_data_nxt  = r_rx_sh;
               w_rx_valid_nxt = 1'b1;
               if (CS_GAP == 0) begin
                  w_tx_ready_nxt = 1'b1;
                  w_busy_nxt     = 1'b0;
               end else begin
                  w_cnt_nxt = L_GAP;
               end
            end
         end
         S_GAP: begin
            if (w_done) begin
               w_tx_ready_nxt = 1'b1;
               w_busy_nxt     = 1'b0;
            end
         end
         default: begin
            w_cs_n_nxt = 1'b1;
         end
      endcase
   end

   assign tx_ready  = r_tx_ready;
   assign rx_data   = r_rx_data;
   assign rx_valid  = r_rx_valid;
   assign busy      = r_busy;
   assign CS_n      = r_cs_n;
   assign SCLK      = r_sclk;
   assign MOSI      = r_mosi;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_spi_master_byte.sv
// Bench for spi_master_byte: three instances (defaults, CS_GAP=0, CLK_DIV=1) checked
// every cycle against a frame-timing model, plus hand-computed literal checks.
`timescale 1ns/1ps
module tb_spi_master_byte;
   localparam int N = 3;

   logic             clk   = 1'b0;
   logic             rst_n = 1'b1;
   logic [N-1:0]     tx_valid, tx_ready, rx_valid, busy, cs_n, sclk, mosi, miso;
   logic [7:0]       tx_data [N];
   logic [7:0]       rx_data [N];
   logic [2:0]       dbg     [N];
   logic             loop0;
   logic [7:0]       pat0;

   int n_tests = 0;
   int n_fail  = 0;
   int n_print = 0;

   // model state: per instance, frame active flag, cycles since accept edge
   bit         m_act  [N];
   int         m_t    [N];
   logic [7:0] m_byte [N];
   logic [7:0] m_rx   [N];
   logic [7:0] m_prev [N];

   // capture traces (index j = sample after accept edge j)
   logic       tr_cs [256];
   logic       tr_sc [256];
   logic       tr_rv [256];
   logic       tr_rd [256];
   logic [7:0] tr_dt [256];

   always #5 clk = ~clk;

   spi_master_byte #(.CLK_DIV(3), .CS_SETUP(1), .CS_HOLD(1), .CS_GAP(2)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
      .tx_ready(tx_ready[0]), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]), .busy(busy[0]),
      .CS_n(cs_n[0]), .SCLK(sclk[0]), .MOSI(mosi[0]), .MISO(miso[0]), .dbg_state(dbg[0]));
   spi_master_byte #(.CLK_DIV(3), .CS_SETUP(1), .CS_HOLD(1), .CS_GAP(0)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
      .tx_ready(tx_ready[1]), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]), .busy(busy[1]),
      .CS_n(cs_n[1]), .SCLK(sclk[1]), .MOSI(mosi[1]), .MISO(miso[1]), .dbg_state(dbg[1]));
   spi_master_byte #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .CS_GAP(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
      .tx_ready(tx_ready[2]), .rx_data(rx_data[2]), .rx_valid(rx_valid[2]), .busy(busy[2]),
      .CS_n(cs_n[2]), .SCLK(sclk[2]), .MOSI(mosi[2]), .MISO(miso[2]), .dbg_state(dbg[2]));

   // ---------------- model (frame timing from the accept edge) ----------------
   function automatic int p_div(input int i); return (i == 2) ? 1 : 3; endfunction
   function automatic int p_gap(input int i); return (i == 1) ? 0 : 2; endfunction
   function automatic int rx_t(input int i);  return 1 + 16 * p_div(i) + 1; endfunction
   function automatic int end_t(input int i); return rx_t(i) + p_gap(i); endfunction

   function automatic int bit_k(input int t, input int d);
      int k;
      if (t < 1) return 0;
      k = (t - 1) / (2 * d);
      return (k > 7) ? 7 : k;
   endfunction

   function automatic logic e_busy(input int i);
      return m_act[i] && (m_t[i] < end_t(i));
   endfunction
   function automatic logic e_cs(input int i);
      return !(m_act[i] && (m_t[i] < rx_t(i)));
   endfunction
   function automatic logic e_sclk(input int i);
      int u;
      if (!m_act[i] || m_t[i] < 1) return 1'b0;
      u = m_t[i] - 1;
      if (u >= 16 * p_div(i)) return 1'b0;
      return ((u / p_div(i)) % 2) == 1;
   endfunction
   function automatic logic e_mosi(input int i);
      int idx;
      if (!m_act[i] || m_t[i] >= 1 + 16 * p_div(i)) return 1'b0;
      idx = 7 - bit_k(m_t[i], p_div(i));
      return m_byte[i][idx];
   endfunction
   function automatic logic e_rxv(input int i);
      return m_act[i] && (m_t[i] == rx_t(i));
   endfunction
   function automatic logic [7:0] e_rxd(input int i);
      return (m_act[i] && m_t[i] >= rx_t(i)) ? m_rx[i] : m_prev[i];
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            m_act[i]  <= 1'b0;
            m_t[i]    <= 0;
            m_byte[i] <= 8'h00;
            m_rx[i]   <= 8'h00;
            m_prev[i] <= 8'h00;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (!e_busy(i) && tx_valid[i]) begin
               if (m_act[i]) m_prev[i] <= m_rx[i];
               m_act[i]  <= 1'b1;
               m_t[i]    <= 0;
               m_byte[i] <= tx_data[i];
               m_rx[i]   <= (i == 0 && !loop0) ? pat0 : tx_data[i];
            end else if (m_act[i] && m_t[i] < 100000) begin
               m_t[i] <= m_t[i] + 1;
            end
         end
      end
   end

   // slave side: loopback, or (instance 0) a fixed byte shifted out MSB first
   logic [2:0] w_k0;
   always_comb w_k0 = 3'(7 - bit_k(m_t[0], 3));
   assign miso[0] = loop0 ? mosi[0] : pat0[w_k0];
   assign miso[1] = mosi[1];
   assign miso[2] = mosi[2];

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input int i, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_print < 40) begin
            n_print++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", name, i, act, exp, $time);
         end
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < N; i++) begin
            check("cs_n",     i, 8'(cs_n[i]),     8'(e_cs(i)));
            check("sclk",     i, 8'(sclk[i]),     8'(e_sclk(i)));
            check("mosi",     i, 8'(mosi[i]),     8'(e_mosi(i)));
            check("busy",     i, 8'(busy[i]),     8'(e_busy(i)));
            check("tx_ready", i, 8'(tx_ready[i]), 8'(!e_busy(i)));
            check("rx_valid", i, 8'(rx_valid[i]), 8'(e_rxv(i)));
            check("rx_data",  i, rx_data[i],      e_rxd(i));
            check("dbg_idle", i, 8'(dbg[i] == 3'd0), 8'(!e_busy(i)));
         end
      end
   end

   // ---------------- driver tasks ----------------
   // returns at the negedge right after the accept edge (t = 0)
   task automatic send(input int i, input logic [7:0] d);
      bit ok;
      ok = 1'b0;
      @(negedge clk);
      tx_data[i]  = d;
      tx_valid[i] = 1'b1;
      for (int w = 0; w < 300; w++) begin
         if (tx_ready[i]) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("send_accept_timeout", i, 8'(ok), 8'd1);
      @(negedge clk);
      tx_valid[i] = 1'b0;
   endtask

   task automatic wait_ready(input int i);
      bit ok;
      ok = 1'b0;
      for (int w = 0; w < 300; w++) begin
         if (tx_ready[i]) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("ready_timeout", i, 8'(ok), 8'd1);
   endtask

   task automatic wait_rxv(input int i);
      bit ok;
      ok = 1'b0;
      for (int w = 0; w < 300; w++) begin
         if (rx_valid[i]) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("rx_valid_timeout", i, 8'(ok), 8'd1);
   endtask

   task automatic capture(input int i, input int n);
      for (int j = 0; j < n; j++) begin
         tr_cs[j] = cs_n[i];
         tr_sc[j] = sclk[i];
         tr_rv[j] = rx_valid[i];
         tr_rd[j] = tx_ready[i];
         tr_dt[j] = rx_data[i];
         if (j < n - 1) @(negedge clk);
      end
   endtask

   // literal frame checks on a captured trace
   task automatic analyze(input int i, input int n, input int d, input logic [7:0] exp_rx,
                          input int exp_rxv_t, input int exp_rdy_t);
      int first_rv, n_rv, first_rdy, cs_low, rises, first_rise, last_fall;
      bit hi_ok, lo_ok, in_hi;
      int hi_len, lo_len;
      first_rv = -1; n_rv = 0; first_rdy = -1; cs_low = 0;
      rises = 0; first_rise = -1; last_fall = -1; hi_ok = 1; lo_ok = 1;
      in_hi = 0; hi_len = 0; lo_len = 0;
      for (int j = 0; j < n; j++) begin
         if (tr_rv[j]) begin
            n_rv++;
            if (first_rv < 0) first_rv = j;
         end
         if (tr_rd[j] && first_rdy < 0) first_rdy = j;
         if (!tr_cs[j] && first_rv < 0) cs_low++;
         if (j > 0 && tr_sc[j] && !tr_sc[j-1]) begin
            rises++;
            if (first_rise < 0) first_rise = j;
            if (last_fall >= 0 && (j - last_fall) != d) lo_ok = 0;
            hi_len = 0;
         end
         if (tr_sc[j]) hi_len++;
         if (j > 0 && !tr_sc[j] && tr_sc[j-1]) begin
            last_fall = j;
            if (hi_len != d) hi_ok = 0;
         end
      end
      check("rxv_edge",     i, 8'(first_rv),   8'(exp_rxv_t));
      check("rxv_count",    i, 8'(n_rv),       8'd1);
      check("rx_byte",      i, (first_rv >= 0) ? tr_dt[first_rv] : 8'hxx, exp_rx);
      check("cs_low_len",   i, 8'(cs_low),     8'(exp_rxv_t));
      check("sclk_pulses",  i, 8'(rises),      8'd8);
      check("sclk_first",   i, 8'(first_rise), 8'(1 + d));
      check("sclk_high_len", i, 8'(hi_ok),     8'd1);
      check("sclk_low_len", i, 8'(lo_ok),      8'd1);
      check("ready_edge",   i, 8'(first_rdy),  8'(exp_rdy_t));
   endtask

   // ---------------- directed tests ----------------
   initial begin
      logic [7:0] vec [4];
      int seen;
      vec = '{8'h5A, 8'hFF, 8'h01, 8'h00};
      tx_valid = '0;
      for (int i = 0; i < N; i++) tx_data[i] = 8'h00;
      loop0 = 1'b1;
      pat0  = 8'h00;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_cs_n",     0, 8'(cs_n),     8'(3'b111));
      check("rst_sclk",     0, 8'(sclk),     8'(3'b000));
      check("rst_mosi",     0, 8'(mosi),     8'(3'b000));
      check("rst_tx_ready", 0, 8'(tx_ready), 8'(3'b111));
      check("rst_busy",     0, 8'(busy),     8'(3'b000));
      check("rst_rx_valid", 0, 8'(rx_valid), 8'(3'b000));
      check("rst_rx_data",  0, rx_data[0],   8'h00);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // loopback, defaults
      send(0, 8'hA5);
      capture(0, 60);
      analyze(0, 60, 3, 8'hA5, 50, 52);

      // non-loopback: the received byte comes from MISO, not the shift-out data
      wait_ready(0);
      loop0 = 1'b0;
      pat0  = 8'h3A;
      send(0, 8'hC5);
      capture(0, 60);
      analyze(0, 60, 3, 8'h3A, 50, 52);
      wait_ready(0);
      loop0 = 1'b1;

      // loopback vector sweep
      for (int v = 0; v < 4; v++) begin
         send(0, vec[v]);
         wait_rxv(0);
         check("sweep_rx", 0, rx_data[0], vec[v]);
         wait_ready(0);
      end

      // held request: data change while busy is ignored, second frame sends the new byte
      @(negedge clk);
      tx_data[0]  = 8'h3C;
      tx_valid[0] = 1'b1;
      repeat (5) @(negedge clk);
      tx_data[0] = 8'hC3;
      wait_rxv(0);
      check("held_first", 0, rx_data[0], 8'h3C);
      @(negedge clk);
      wait_rxv(0);
      check("held_second", 0, rx_data[0], 8'hC3);
      tx_valid[0] = 1'b0;
      wait_ready(0);

      // back-to-back with CS_GAP=0
      @(negedge clk);
      tx_data[1]  = 8'h81;
      tx_valid[1] = 1'b1;
      seen = 0;
      for (int w = 0; w < 10 && !busy[1]; w++) @(negedge clk);
      check("b2b_start", 1, 8'(busy[1]), 8'd1);
      capture(1, 110);
      tx_valid[1] = 1'b0;
      check("b2b_rxv1",   1, 8'(tr_rv[50]), 8'd1);
      check("b2b_rdy1",   1, 8'(tr_rd[50]), 8'd1);
      check("b2b_cs_hi",  1, 8'(tr_cs[50]), 8'd1);
      check("b2b_cs_lo",  1, 8'(tr_cs[51]), 8'd0);
      check("b2b_rx1",    1, tr_dt[50],     8'h81);
      check("b2b_rxv2",   1, 8'(tr_rv[101]), 8'd1);
      check("b2b_rdy2",   1, 8'(tr_rd[101]), 8'd1);
      check("b2b_cs_lo2", 1, 8'(tr_cs[102]), 8'd0);
      check("b2b_rx2",    1, tr_dt[101],    8'h81);
      wait_ready(1);

      // minimum divider
      send(2, 8'h96);
      capture(2, 25);
      analyze(2, 25, 1, 8'h96, 18, 20);
      wait_ready(2);

      // reset during bit 4 (SCLK high, MOSI=1 for 0xFF)
      send(0, 8'hFF);
      repeat (22) @(negedge clk);
      check("pre_rst_sclk", 0, 8'(sclk[0]), 8'd1);
      check("pre_rst_mosi", 0, 8'(mosi[0]), 8'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_cs_n",     0, 8'(cs_n[0]),     8'd1);
      check("mid_rst_sclk",     0, 8'(sclk[0]),     8'd0);
      check("mid_rst_mosi",     0, 8'(mosi[0]),     8'd0);
      check("mid_rst_tx_ready", 0, 8'(tx_ready[0]), 8'd1);
      check("mid_rst_busy",     0, 8'(busy[0]),     8'd0);
      check("mid_rst_rx_data",  0, rx_data[0],      8'h00);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int w = 0; w < 60; w++) begin
         @(negedge clk);
         if (rx_valid[0]) seen++;
      end
      check("no_rxv_after_rst", 0, 8'(seen), 8'd0);
      send(0, 8'h55);
      capture(0, 60);
      analyze(0, 60, 3, 8'h55, 50, 52);

      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
